// File: rtl/filtro_control_pb200.sv
// -----------------------------------------------------------------------------
// filtro_control_pb200
//
// Sequencer for the 200 Hz low-pass filter datapath. Each sample strobe walks
// the shared MAC unit (resultado = dato1*dato2 + dato3) through one complete
// filter update:
//
//   SHIFT : fk2 <= fk1, fk1 <= fk
//   M1..M3: fk    = b0*uk - a1*fk1 - a2*fk2      (recursive section)
//   M4..M7: yk    = g*(fk2 + 2*fk1 + fk)         (1-2-1 numerator, gain g)
//   DONE  : yk holds the new output sample
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset (shared with the datapath)
//   start    in   one-cycle sample strobe per new uk
//   en1..en7 out  register enables: yk, fk, fk1, fk2, acum1, acum2, acum3
//   selmuxS  out  signal operand   : 0=uk 1=fk 2=fk1 3=fk2
//   selmuxC  out  coefficient index: 0=b0 1=-a1 2=-a2 3=g
//   selmuxZ  out  addend           : 0=zero 1=acum1 2=acum2 3=acum3
//   busy     out  high from SHIFT through DONE
//   done     out  one-cycle pulse, yk holds the new sample
//   overrun  out  sticky, a strobe was dropped
//
// All datapath controls are Moore outputs. They are registered from the
// next-state value so that they line up exactly with the state register and
// leave the block without any combinational path from start.
// -----------------------------------------------------------------------------
module filtro_control_pb200 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SHIFT = 4'd1,
        M1    = 4'd2,
        M2    = 4'd3,
        M3    = 4'd4,
        M4    = 4'd5,
        M5    = 4'd6,
        M6    = 4'd7,
        M7    = 4'd8,
        DONE  = 4'd9
    } state_t;

    // Operand-mux encodings shared with the datapath.
    localparam logic [2:0] S_UK  = 3'd0;
    localparam logic [2:0] S_FK  = 3'd1;
    localparam logic [2:0] S_FK1 = 3'd2;
    localparam logic [2:0] S_FK2 = 3'd3;

    localparam logic [1:0] C_B0  = 2'd0;
    localparam logic [1:0] C_A1  = 2'd1;
    localparam logic [1:0] C_A2  = 2'd2;
    localparam logic [1:0] C_G   = 2'd3;

    localparam logic [2:0] Z_ZERO = 3'd0;
    localparam logic [2:0] Z_AC1  = 3'd1;
    localparam logic [2:0] Z_AC2  = 3'd2;
    localparam logic [2:0] Z_AC3  = 3'd3;

    // Enable vector order: en[6]=en1 (yk) ... en[0]=en7 (acum3).
    localparam logic [6:0] EN_YK  = 7'b1000000;
    localparam logic [6:0] EN_FK  = 7'b0100000;
    localparam logic [6:0] EN_FK1 = 7'b0010000;
    localparam logic [6:0] EN_FK2 = 7'b0001000;
    localparam logic [6:0] EN_AC1 = 7'b0000100;
    localparam logic [6:0] EN_AC2 = 7'b0000010;
    localparam logic [6:0] EN_AC3 = 7'b0000001;

    typedef struct packed {
        logic [6:0] en;
        logic [2:0] s;
        logic [1:0] c;
        logic [2:0] z;
        logic       busy;
        logic       done;
    } ctl_t;

    state_t state_q, state_d;
    logic   pending_q, pending_d;
    logic   overrun_q, overrun_d;
    ctl_t   ctl_q;

    // Moore decode of the datapath controls for one state.
    function automatic ctl_t decode(input state_t st);
        ctl_t o;
        o = '0;
        case (st)
            SHIFT: begin
                o.en   = EN_FK1 | EN_FK2;
                o.busy = 1'b1;
            end
            M1: begin
                o.en = EN_AC1; o.s = S_FK1; o.c = C_A1; o.z = Z_ZERO;
                o.busy = 1'b1;
            end
            M2: begin
                o.en = EN_AC2; o.s = S_FK2; o.c = C_A2; o.z = Z_AC1;
                o.busy = 1'b1;
            end
            M3: begin
                o.en = EN_FK;  o.s = S_UK;  o.c = C_B0; o.z = Z_AC2;
                o.busy = 1'b1;
            end
            M4: begin
                o.en = EN_AC3; o.s = S_FK2; o.c = C_G;  o.z = Z_ZERO;
                o.busy = 1'b1;
            end
            // M5 and M6 both add g*fk1 to build the centre tap of 1-2-1.
            M5, M6: begin
                o.en = EN_AC3; o.s = S_FK1; o.c = C_G;  o.z = Z_AC3;
                o.busy = 1'b1;
            end
            M7: begin
                o.en = EN_YK;  o.s = S_FK;  o.c = C_G;  o.z = Z_AC3;
                o.busy = 1'b1;
            end
            DONE: begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE:  if (start) state_d = SHIFT;
            SHIFT: state_d = M1;
            M1:    state_d = M2;
            M2:    state_d = M3;
            M3:    state_d = M4;
            M4:    state_d = M5;
            M5:    state_d = M6;
            M6:    state_d = M7;
            M7:    state_d = DONE;
            DONE: begin
                // A strobe arriving in DONE counts as a busy-time strobe; with
                // no sample queued it is consumed at once by restarting.
                if (pending_q || start) begin
                    state_d   = SHIFT;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
                if (start && pending_q) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Strobes during SHIFT..M7 queue one sample; a second one is lost.
        if (start && (state_q >= SHIFT) && (state_q <= M7)) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            ctl_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            ctl_q     <= decode(state_d);
        end
    end

    assign en1     = ctl_q.en[6];
    assign en2     = ctl_q.en[5];
    assign en3     = ctl_q.en[4];
    assign en4     = ctl_q.en[3];
    assign en5     = ctl_q.en[2];
    assign en6     = ctl_q.en[1];
    assign en7     = ctl_q.en[0];
    assign selmuxS = ctl_q.s;
    assign selmuxC = ctl_q.c;
    assign selmuxZ = ctl_q.z;
    assign busy    = ctl_q.busy;
    assign done    = ctl_q.done;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_filtro_control_pb200.sv
module tb_filtro_control_pb200;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       en1, en2, en3, en4, en5, en6, en7;
    logic [2:0] selmuxS;
    logic [1:0] selmuxC;
    logic [2:0] selmuxZ;
    logic       busy, done, overrun;

    int nvec = 0;
    int nerr = 0;

    filtro_control_pb200 dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .en1     (en1),
        .en2     (en2),
        .en3     (en3),
        .en4     (en4),
        .en5     (en5),
        .en6     (en6),
        .en7     (en7),
        .selmuxS (selmuxS),
        .selmuxC (selmuxC),
        .selmuxZ (selmuxZ),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // {en1..en7, S, C, Z, busy, done}
    logic [16:0] obs_v;
    assign obs_v = {en1, en2, en3, en4, en5, en6, en7,
                    selmuxS, selmuxC, selmuxZ, busy, done};

    // Small datapath model: coefficients b0=1, -a1=0, -a2=0, g=1.
    int uk;
    int yk_m, fk_m, fk1_m, fk2_m, ac1_m, ac2_m, ac3_m;
    int sig_v, coef_v, add_v, res_v;

    always_comb begin
        sig_v = 0; coef_v = 0; add_v = 0;
        case (selmuxS)
            3'd0: sig_v = uk;
            3'd1: sig_v = fk_m;
            3'd2: sig_v = fk1_m;
            3'd3: sig_v = fk2_m;
            default: sig_v = 0;
        endcase
        case (selmuxC)
            2'd0: coef_v = 1;
            2'd1: coef_v = 0;
            2'd2: coef_v = 0;
            default: coef_v = 1;
        endcase
        case (selmuxZ)
            3'd1: add_v = ac1_m;
            3'd2: add_v = ac2_m;
            3'd3: add_v = ac3_m;
            default: add_v = 0;
        endcase
        res_v = coef_v * sig_v + add_v;
    end

    always @(posedge clk) begin
        if (reset) begin
            yk_m <= 0; fk_m <= 0; fk1_m <= 0; fk2_m <= 0;
            ac1_m <= 0; ac2_m <= 0; ac3_m <= 0;
        end else begin
            if (en1) yk_m  <= res_v;
            if (en2) fk_m  <= res_v;
            if (en3) fk1_m <= fk_m;
            if (en4) fk2_m <= fk1_m;
            if (en5) ac1_m <= res_v;
            if (en6) ac2_m <= res_v;
            if (en7) ac3_m <= res_v;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Hand-written control word for step 0=IDLE, 1=SHIFT, 2..8=M1..M7, 9=DONE.
    function automatic logic [16:0] exp_vec(input int st);
        case (st)
            1: return {7'b0011000, 3'd0, 2'd0, 3'd0, 1'b1, 1'b0};
            2: return {7'b0000100, 3'd2, 2'd1, 3'd0, 1'b1, 1'b0};
            3: return {7'b0000010, 3'd3, 2'd2, 3'd1, 1'b1, 1'b0};
            4: return {7'b0100000, 3'd0, 2'd0, 3'd2, 1'b1, 1'b0};
            5: return {7'b0000001, 3'd3, 2'd3, 3'd0, 1'b1, 1'b0};
            6: return {7'b0000001, 3'd2, 2'd3, 3'd3, 1'b1, 1'b0};
            7: return {7'b0000001, 3'd2, 2'd3, 3'd3, 1'b1, 1'b0};
            8: return {7'b1000000, 3'd1, 2'd3, 3'd3, 1'b1, 1'b0};
            9: return {7'b0000000, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1};
            default: return 17'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One strobe from IDLE, checks the full step sequence and return to IDLE.
    task automatic single(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int st = 1; st <= 9; st++) begin
            chk($sformatf("%s_c%0d", tag, st), {15'd0, obs_v}, {15'd0, exp_vec(st)});
            tick();
        end
        chk($sformatf("%s_c10_idle", tag), {15'd0, obs_v}, 32'd0);
        tick();
    endtask

    // Strobe schedule given as a cycle mask; two = second sequence expected
    // in cycles 10..18; overrun expected high in cycles after ovr_c (-1: never).
    task automatic sched(input string tag, input logic [31:0] mask,
                         input bit two, input int ovr_c, input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            int st;
            st = 0;
            if (c >= 1 && c <= 9) st = c;
            else if (two && c >= 10 && c <= 18) st = c - 9;
            chk($sformatf("%s_c%0d", tag, c), {15'd0, obs_v}, {15'd0, exp_vec(st)});
            chk($sformatf("%s_ovr_c%0d", tag, c), {31'd0, overrun},
                {31'd0, (ovr_c >= 0 && c > ovr_c)});
            start = mask[c];
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int exp_yk [4];
        exp_yk = '{1, 2, 1, 0};
        start = 1'b0;
        uk    = 0;

        // Reset and idle
        reset = 1'b1;
        tick();
        chk("rst_vec", {15'd0, obs_v}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("idle_%0d", i), {14'd0, obs_v, overrun}, 32'd0);
            tick();
        end

        // Single strobe
        single("single");

        // Closed loop with the datapath model
        do_reset();
        for (int k = 0; k < 4; k++) begin
            int n;
            uk    = (k == 0) ? 1 : 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (!done && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("loop%0d_done_wait", k), {31'd0, (n < 20)}, 32'd1);
            chk($sformatf("loop%0d_yk", k), yk_m, exp_yk[k]);
            chk($sformatf("loop%0d_fk", k), fk_m, (k == 0) ? 1 : 0);
            chk($sformatf("loop%0d_fk1", k), fk1_m, (k == 1) ? 1 : 0);
            chk($sformatf("loop%0d_fk2", k), fk2_m, (k == 2) ? 1 : 0);
            tick();
        end

        // Queued strobe at cycle 4
        do_reset();
        sched("queue", 32'h0000_0011, 1'b1, -1, 20);

        // Strobe in the DONE cycle is queued with no IDLE gap
        do_reset();
        sched("qdone", 32'h0000_0201, 1'b1, -1, 20);

        // Overrun: strobes at 0, 3, 5
        do_reset();
        sched("ovr", 32'h0000_0029, 1'b1, 5, 21);

        // Reset during M3 (overrun still set from above, pending set at 2)
        for (int c = 0; c <= 4; c++) begin
            chk($sformatf("midrst_c%0d", c), {15'd0, obs_v}, {15'd0, exp_vec(c)});
            chk($sformatf("midrst_ovr_c%0d", c), {31'd0, overrun}, 32'd1);
            start = (c == 0 || c == 2);
            if (c == 4) begin
                start = 1'b0;
                reset = 1'b1;
            end
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("postrst_%0d", i), {14'd0, obs_v, overrun}, 32'd0);
            tick();
        end
        single("fresh");
        chk("fresh_idle", {14'd0, obs_v, overrun}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/filtro_control_pb200.md
Name: filtro_control_pb200

Overview:
- Sequencer (control unit) for the 200 Hz low-pass filter datapath.
- On each sample strobe it drives the seven register enables and the three operand-mux selects of the datapath, stepping the shared MAC unit (resultado = dato1*dato2 + dato3) through one full filter update.
- Sits directly upstream of the datapath and shares its clock and reset.
- Flags when yk holds the new output sample.

Parameters:
- None. All encodings and the step sequence below are fixed.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  sample strobe; one-cycle pulse per new uk
- en1  output  1  enable, yk register
- en2  output  1  enable, fk register
- en3  output  1  enable, fk1 register (loads fk)
- en4  output  1  enable, fk2 register (loads fk1)
- en5  output  1  enable, accumulator 1
- en6  output  1  enable, accumulator 2
- en7  output  1  enable, accumulator 3
- selmuxS  output  3  signal operand: 0=uk, 1=fk, 2=fk1, 3=fk2, others reserved (never driven)
- selmuxC  output  2  coefficient index 0..3 (C0=b0, C1=-a1, C2=-a2, C3=output gain g)
- selmuxZ  output  3  addend: 0=zero, 1=acum1, 2=acum2, 3=acum3, others reserved
- busy  output  1  high from SHIFT through DONE
- done  output  1  one-cycle pulse; yk holds the new sample
- overrun  output  1  sticky; a strobe was lost

Behaviour:
- Moore FSM; all outputs decode from the registered state only.
- Default for every output in every state: enables 0, selects 0.
- Reset (any cycle, including mid-sequence):
  - state=IDLE; pending=0; overrun=0; all outputs 0.
  - The datapath registers are reset by the same signal.
- State sequence, one cycle per state. Each step writes resultado into the named register at the end of its cycle.
  - IDLE: start=1 -> SHIFT; else stay.
  - SHIFT: en3=1, en4=1 (fk2<=fk1, fk1<=fk in the same edge).
  - M1: S=2, C=1, Z=0, en5 (acum1 = -a1*fk1).
  - M2: S=3, C=2, Z=1, en6 (acum2 = -a2*fk2 + acum1).
  - M3: S=0, C=0, Z=2, en2 (fk = b0*uk + acum2).
  - M4: S=3, C=3, Z=0, en7 (acum3 = g*fk2).
  - M5: S=2, C=3, Z=3, en7 (acum3 += g*fk1).
  - M6: S=2, C=3, Z=3, en7 (acum3 += g*fk1; gives the 1-2-1 numerator).
  - M7: S=1, C=3, Z=3, en1 (yk = g*fk + acum3).
  - DONE: done=1. If pending=1 -> SHIFT and clear pending; else -> IDLE.
- Latency: start high at edge e0 gives SHIFT in cycle 1, DONE in cycle 9, and yk updated at the edge ending M7. Throughput is at most one sample per 9 cycles.
- busy=1 in SHIFT..DONE; 0 in IDLE.
- start while busy:
  - pending=0: set pending. That sample starts right after DONE with no IDLE cycle between.
  - pending=1: set overrun (sticky until reset). The extra strobe is dropped.
- start in the same cycle as DONE is treated as "busy". It sets pending, or raises overrun if pending is already set.
- start held high continuously: one sequence per 9 cycles. pending re-arms each pass; overrun asserts on the second strobe seen while pending.
- uk must be stable from start through M3; the block does not sample uk itself.
- Unreachable state encodings -> IDLE on the next edge, with outputs at defaults.

Test Plan:
- Reset then idle: hold reset 2 cycles, start=0 for 20 cycles -> all enables, selects, busy, done and overrun stay 0.
- Single strobe: pulse start at cycle 0 -> SHIFT asserts en3=en4=1 at cycle 1. en5/en6/en2/en7/en7/en7/en1 follow in cycles 2-8 with the exact S/C/Z codes listed. done=1 only in cycle 9. busy=1 in cycles 1-9. Return to IDLE at cycle 10.
- Closed loop with the datapath, coefficients b0=1, -a1=0, -a2=0, g=1, uk=1 pulsed for one sample then 0:
  - Outputs sample by sample: yk = 1, 2, 1, 0.
  - fk/fk1/fk2 shift correctly between samples.
- Queued strobe: start at cycle 0 and again at cycle 4 -> second SHIFT in cycle 10 directly after DONE. Two done pulses, at cycles 9 and 18. overrun=0.
- Overrun: strobes at cycles 0, 3 and 5 -> overrun rises after cycle 5 and stays 1. Only two sequences run.
- Reset mid-operation: assert reset during M3 -> next cycle IDLE with all outputs 0 and pending cleared. A fresh strobe afterwards runs a clean 9-cycle sequence.
